spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI slave front-end with an internal 64 x 12-bit register file, clocked entirely in the sys_clk domain.
//  An external master writes registers or requests reads with 32-bit frames sent LSB first.
//  Read data is pipelined: a read frame loads a response word, and the master shifts it out on the NEXT frame.
//  sclk, cs_n and mosi are asynchronous; they are oversampled (sys_clk >= 4x sclk).
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages on each of sclk, cs_n and mosi (same depth on all three)
//  NUM_REGS     64  register count; the address field is 6 bits and every value is valid
//  DATA_W       12  register width; frame field layout below is fixed
// PORTS
//  sys_clk  in   1  system clock (100 MHz nominal)
//  rstn     in   1  reset, asynchronous, active-low
//  sclk     in   1  SPI clock from master, idle low, up to sys_clk/4
//  cs_n     in   1  SPI chip select, active-low; frame boundary
//  mosi     in   1  serial data from master, valid at sclk rising edge
//  miso     out  1  serial data to master, valid at sclk rising edge
// BEHAVIOUR
//  Clock/reset: one clock, sys_clk. Reset is asynchronous and active-low on rstn.
//  Reset clears: all regs = 0, response buffer = 0, bit counter = 0, synchronizers idle (sclk=0, cs_n=1).
//  Reset mid-frame aborts the frame with no register update. miso = 0 while in reset.
//  Synchronizers: sclk, cs_n and mosi pass through identical SYNC_STAGES chains.
//  - Edges are detected on the synchronized sclk and cs_n.
//  - Synchronized mosi is sampled on the detected sclk rise.
//  Frame layout (bit 0 sent first):
//  - [0] rwb: 1 = read, 0 = write
//  - [7:1] reserved
//  - [13:8] addr
//  - [15:14] reserved
//  - [27:16] data
//  - [31:28] reserved
//  - Reserved bits are ignored on receive.
//  Receive: while synchronized cs_n = 0, each sclk rise shifts mosi into rx_shift[31]; the register shifts right.
//  - The bit counter saturates at 33.
//  - sclk edges while cs_n = 1 are ignored.
//  Commit: on the synchronized cs_n rising edge, the frame is acted on only if the counter == 32. Then the counter clears.
//  - Write (rwb = 0): regs[addr] <= data. Response buffer <= 0.
//  - Read (rwb = 1): response buffer <= {4'h0, regs[addr], 2'b00, addr, 7'h00, 1'b1}.
//  - Counter != 32 (short or long frame): no update of regs or the response buffer.
//  Transmit: on the cs_n falling edge, tx_shift <= response buffer.
//  - miso = tx_shift[0] while raw cs_n = 0; miso = 0 while cs_n = 1.
//  - tx_shift shifts right (fill 0) on each detected sclk rise, i.e. after the master samples that bit.
//  - With a 2-stage synchronizer the shift lands in the sclk low phase, ahead of the next rise.
//  Simultaneous events: if the final sclk rise and the cs_n rise are detected in the same cycle, shift in first, then commit.
//  Read-after-write: a write to addr A followed by read frames of A returns the new value in the second read frame.
//  Back-to-back frames: frames separated by at least (SYNC_STAGES + 2) sys_clk cycles of cs_n high are handled correctly.
//  Total latency: cs_n rise to register update is SYNC_STAGES + 2 sys_clk cycles or fewer.
// TESTING
//  1. Reset: rstn low, then high; read frame to addr 59, then a second frame -> second frame's miso word = 0x0000_3B01 (data 0).
//  2. Write: frame 0x000C_0C00 (addr 12, data 0x00C, rwb = 0) -> regs[12] = 0x00C; other regs unchanged.
//  3. Pipelined read: two read frames to addr 12 (0x0000_0C01) -> second frame's miso word = 0x000C_0C01.
//  4. Read of an unwritten register: two read frames to addr 23 -> second frame's miso word = 0x0000_1701.
//  5. Abort: cs_n raised after 20 bits of a write frame -> no reg change; a following 32-bit frame decodes correctly.
//  6. Reset mid-frame: rstn low at bit 10 of a write frame -> all regs 0; the next complete frame works.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front-end with a 64 x 12-bit register file.
// sclk, cs_n and mosi are oversampled in the sys_clk domain. 32-bit frames
// arrive LSB first. A read frame loads a response word, and that word is
// shifted out on miso during the following frame.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 64,
  parameter int DATA_W      = 12
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int FRAME_W = 32;
  localparam logic [5:0] CNT_FULL = 6'd32;
  localparam logic [5:0] CNT_SAT  = 6'd33;

  // Synchronizer chains. Index 0 samples the pin, and the top index is the
  // synchronized value. All three chains have the same depth, so mosi stays
  // aligned with the sclk edge that samples it.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;

  logic sclk_rise, cs_rise, cs_fall, frame_active, take_bit;

  logic [FRAME_W-1:0] rx_shift, rx_next;
  logic [5:0]         bit_cnt, cnt_next;
  logic [FRAME_W-1:0] tx_shift;
  logic [FRAME_W-1:0] resp;

  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic               commit;
  logic               rx_rwb;
  logic [ADDR_W-1:0]  rx_addr;
  logic [DATA_W-1:0]  rx_data;

  // Shift the pins into the synchronizer chains. Reset puts the chains in the idle bus state.
  // NOTE: state is registered with non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync[0] <= sclk;
      cs_sync[0]   <= cs_n;
      mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Hold the previous synchronized sclk and cs_n levels for edge detection.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  // The frame still counts as open in the cycle where cs_n rises. A final
  // sclk rise detected in that same cycle is therefore taken before the commit.
  assign frame_active = ~cs_s | ~cs_d;
  assign take_bit     = sclk_rise & frame_active;

  // Next receive state: LSB-first shift into bit 31, and a counter that saturates at 33.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rx_next  = rx_shift;
    cnt_next = bit_cnt;
    if (take_bit) begin
      rx_next = {mosi_s, rx_shift[FRAME_W-1:1]};
      if (bit_cnt != CNT_SAT) cnt_next = bit_cnt + 6'd1;
    end
  end

  assign commit  = cs_rise && (cnt_next == CNT_FULL);
  assign rx_rwb  = rx_next[0];
  assign rx_addr = rx_next[8 +: ADDR_W];
  assign rx_data = rx_next[16 +: DATA_W];

  // Receive shifter and bit counter. The counter clears when cs_n rises.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_shift <= rx_next;
      bit_cnt  <= cs_rise ? 6'd0 : cnt_next;
    end
  end

  // Register file. A committed write frame updates one entry.
  // NOTE: this storage has to read back as zero after reset, so every entry is
  // cleared explicitly. That makes it a flop array rather than a RAM macro.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && !rx_rwb) begin
      regs[rx_addr] <= rx_data;
    end
  end

  // Response buffer. A read loads the formatted reply, and a write clears it.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      resp <= '0;
    end else if (commit) begin
      if (rx_rwb) resp <= {4'h0, regs[rx_addr], 2'b00, rx_addr, 7'h00, 1'b1};
      else        resp <= '0;
    end
  end

  // Transmit shifter. It loads at frame start and advances after the master samples each bit.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      tx_shift <= '0;
    end else if (cs_fall) begin
      tx_shift <= resp;
    end else if (take_bit) begin
      tx_shift <= {1'b0, tx_shift[FRAME_W-1:1]};
    end
  end

  // miso is gated by the raw chip select so the line is quiet as soon as the master deselects.
  assign miso = ~cs_n & tx_shift[0];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. The bench plays the SPI master at
// sys_clk/8. Expected miso words are queued as each frame is driven, and the
// words captured from the DUT are popped and compared against them.
module tb_spi_slave;

  logic sys_clk = 1'b0;
  logic rstn, sclk, cs_n, mosi;
  logic miso;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  string       name_q[$];

  always #5 sys_clk = ~sys_clk;

  spi_slave #(.SYNC_STAGES(2), .NUM_REGS(64), .DATA_W(12)) dut (
    .sys_clk(sys_clk),
    .rstn   (rstn),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  // Send n bits LSB first. miso is captured just before each sclk rise,
  // which is the point where the master samples it.
  task automatic shift_bits(input logic [63:0] tx, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[i];
      wait_clk(4);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Send one framed transfer of n bits. The expected miso word (lower bits
  // only, for a short frame) is queued here when the frame is driven.
  task automatic frame(input string name, input logic [31:0] tx, input logic [31:0] exp, input int n = 32);
    logic [63:0] rx;
    exp_q.push_back(exp);
    name_q.push_back(name);
    cs_low();
    shift_bits({32'h0, tx}, n, rx);
    cs_high();
    got_q.push_back(rx[31:0]);
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    string nm;
    rstn = 1'b0; cs_n = 1'b0; sclk = 1'b0; mosi = 1'b0;
    wait_clk(3);
    compared++;
    if (miso !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_miso_in_reset: got %b want 0", miso);
    end
    cs_n = 1'b1;
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(8);
    compared++;
    if (miso !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_miso_idle: got %b want 0", miso);
    end
    frame("reset_rd59_a", 32'h0000_3B01, 32'h0000_0000);
    frame("reset_rd59_b", 32'h0000_3B01, 32'h0000_3B01);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] e, g;
    string nm;
    frame("wr12",     32'h000C_0C00, 32'h0000_3B01);
    frame("rd13_a",   32'h0000_0D01, 32'h0000_0000);
    frame("rd11_a",   32'h0000_0B01, 32'h0000_0D01);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  task automatic test_pipelined_read();
    logic [31:0] e, g;
    string nm;
    frame("rd12_a", 32'h0000_0C01, 32'h0000_0B01);
    frame("rd12_b", 32'h0000_0C01, 32'h000C_0C01);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  task automatic test_unwritten_read();
    logic [31:0] e, g;
    string nm;
    frame("rd23_a", 32'h0000_1701, 32'h000C_0C01);
    frame("rd23_b", 32'h0000_1701, 32'h0000_1701);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  // Short (20-bit) and long (34-bit) write frames to addr 23 must change
  // neither the register nor the response buffer.
  task automatic test_abort();
    logic [31:0] e, g;
    string nm;
    frame("abort_wr23_20b",   32'h0ABC_1700, 32'h0000_1701, 20);
    frame("abort_rd23_a",     32'h0000_1701, 32'h0000_1701);
    frame("long_wr23_34b",    32'h0ABC_1700, 32'h0000_1701, 34);
    frame("long_rd23_a",      32'h0000_1701, 32'h0000_1701);
    frame("long_rd23_b",      32'h0000_1701, 32'h0000_1701);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  // Consecutive write/read frames, with the extreme addresses and data values
  // and with every reserved bit set.
  task automatic test_back_to_back();
    logic [31:0] e, g;
    string nm;
    frame("b2b_wr5",      32'h05A5_0500, 32'h0000_1701);
    frame("b2b_rd5_a",    32'h0000_0501, 32'h0000_0000);
    frame("b2b_rd5_b",    32'h0000_0501, 32'h05A5_0501);
    frame("b2b_wr63",     32'h0FFF_3F00, 32'h05A5_0501);
    frame("b2b_rd63",     32'h0000_3F01, 32'h0000_0000);
    frame("b2b_rd0",      32'h0000_0001, 32'h0FFF_3F01);
    frame("rsvd_wr0",     32'hF123_C0FE, 32'h0000_0001);
    frame("rsvd_rd0_a",   32'h0000_0001, 32'h0000_0000);
    frame("rsvd_rd0_b",   32'h0000_0001, 32'h0123_0001);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] e, g;
    logic [63:0] rx;
    string nm;
    cs_low();
    shift_bits({32'h0, 32'h0111_0500}, 10, rx);
    rstn = 1'b0;
    wait_clk(2);
    compared++;
    if (miso !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_miso_in_reset: got %b want 0", miso);
    end
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(8);
    frame("midrst_rd12",   32'h0000_0C01, 32'h0000_0000);
    frame("midrst_rd63",   32'h0000_3F01, 32'h0000_0C01);
    frame("midrst_rd5",    32'h0000_0501, 32'h0000_3F01);
    frame("midrst_wr12",   32'h0777_0C00, 32'h0000_0501);
    frame("midrst_rd12_a", 32'h0000_0C01, 32'h0000_0000);
    frame("midrst_rd12_b", 32'h0000_0C01, 32'h0777_0C01);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: miso word got 0x%08h want 0x%08h", nm, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_pipelined_read();
    test_unwritten_read();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
